// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: datapath widths, RV32 funct3
// load/store encodings, response error codes, FSM states and the registered
// memory command payload.
package lsu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned STRB_W = XLEN / 8;

  // RV32 funct3 encodings (stores only use B/H/W)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_BUS      = 2'b10,
    ERR_ILLEGAL  = 2'b11
  } err_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_e;

  // Data-memory command, held stable for the whole ACCESS phase
  typedef struct packed {
    logic              we;
    logic [XLEN-1:0]   addr;
    logic [STRB_W-1:0] wstrb;
    logic [XLEN-1:0]   wdata;
  } mem_cmd_t;

endpackage

// File: rtl/lsu_if.sv
// Interfaces around the load/store unit.
//   lsu_req_if : control path <-> lsu (en, request handshake, response, busy)
//                master = control path, slave = lsu
//   lsu_mem_if : lsu <-> data memory (mem_req/mem_ready handshake)
//                master = lsu, slave = memory
interface lsu_req_if;
  import lsu_pkg::*;

  logic             en;
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [2:0]       req_funct3;
  logic [XLEN-1:0]  req_addr;
  logic [XLEN-1:0]  req_wdata;
  logic             rsp_valid;
  logic [XLEN-1:0]  rsp_rdata;
  logic [1:0]       rsp_err;
  logic             busy;

  modport master (
    output en, req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  en, req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

interface lsu_mem_if;
  import lsu_pkg::*;

  logic              mem_req;
  logic              mem_we;
  logic [XLEN-1:0]   mem_addr;
  logic [STRB_W-1:0] mem_wstrb;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_ready;
  logic [XLEN-1:0]   mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic for the lsu.
// Store side (fed by the incoming request): lane-replicated write data,
//   byte strobes, illegal-funct3 and misalignment flags.
// Load side (fed by the registered request): byte/half selection from the
//   read word with sign or zero extension.
// Ports:
//   st_we_i, st_funct3_i, st_off_i, st_wdata_i : incoming request fields
//   st_wdata_o, st_wstrb_o                     : write data / strobes (0 for loads)
//   illegal_o, misalign_o                      : request classification
//   ld_funct3_i, ld_off_i, ld_rdata_i          : registered load info + read word
//   ld_data_o                                  : extended load result
module lsu_align
  import lsu_pkg::*;
(
  input  logic              st_we_i,
  input  logic [2:0]        st_funct3_i,
  input  logic [1:0]        st_off_i,
  input  logic [XLEN-1:0]   st_wdata_i,
  output logic [XLEN-1:0]   st_wdata_o,
  output logic [STRB_W-1:0] st_wstrb_o,
  output logic              illegal_o,
  output logic              misalign_o,
  input  logic [2:0]        ld_funct3_i,
  input  logic [1:0]        ld_off_i,
  input  logic [XLEN-1:0]   ld_rdata_i,
  output logic [XLEN-1:0]   ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Request classification and store lane replication
  always_comb begin
    st_wdata_o = '0;
    st_wstrb_o = '0;
    illegal_o  = 1'b0;
    misalign_o = 1'b0;
    case (st_funct3_i)
      F3_B: begin
        st_wdata_o = {4{st_wdata_i[7:0]}};
        st_wstrb_o = 4'b0001 << st_off_i;
      end
      F3_H: begin
        st_wdata_o = {2{st_wdata_i[15:0]}};
        st_wstrb_o = st_off_i[1] ? 4'b1100 : 4'b0011;
        misalign_o = st_off_i[0];
      end
      F3_W: begin
        st_wdata_o = st_wdata_i;
        st_wstrb_o = 4'b1111;
        misalign_o = |st_off_i;
      end
      // Unsigned variants exist only for loads
      F3_BU: illegal_o = st_we_i;
      F3_HU: begin
        illegal_o  = st_we_i;
        misalign_o = st_off_i[0];
      end
      default: illegal_o = 1'b1;
    endcase
    if (!st_we_i) begin
      st_wdata_o = '0;
      st_wstrb_o = '0;
    end
  end

  assign ld_byte = ld_rdata_i[{ld_off_i, 3'b000} +: 8];
  assign ld_half = ld_rdata_i[{ld_off_i[1], 4'b0000} +: 16];

  // Load extension
  always_comb begin
    ld_data_o = '0;
    case (ld_funct3_i)
      F3_B:    ld_data_o = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      F3_H:    ld_data_o = {{(XLEN-16){ld_half[15]}}, ld_half};
      F3_W:    ld_data_o = ld_rdata_i;
      F3_BU:   ld_data_o = {{(XLEN-8){1'b0}}, ld_byte};
      F3_HU:   ld_data_o = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_data_o = '0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit downstream of the ALU. Accepts one load/store at a time,
// runs a mem_req/mem_ready access on the data-memory port (with a bus
// timeout), and returns a one-cycle response with extended load data or an
// error code. Requests with illegal funct3 or misaligned addresses are
// answered directly without touching memory.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   req      : control-path side (en, request handshake, response, busy)
//   mem      : data-memory side (command, ready, read data)
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic      clk,
  input  logic      rst,
  lsu_req_if.slave  req,
  lsu_mem_if.master mem
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  if (DATA_WIDTH != XLEN) begin : g_bad_width
    $error("lsu: only DATA_WIDTH = 32 is supported");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("lsu: TIMEOUT must be at least 1");
  end

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  mem_cmd_t          mem_q, mem_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  err_e              err_q, err_d;

  logic [XLEN-1:0]   st_wdata;
  logic [STRB_W-1:0] st_wstrb;
  logic              illegal;
  logic              misalign;
  logic [XLEN-1:0]   ld_data;

  lsu_align u_align (
    .st_we_i     (req.req_we),
    .st_funct3_i (req.req_funct3),
    .st_off_i    (req.req_addr[1:0]),
    .st_wdata_i  (req.req_wdata),
    .st_wdata_o  (st_wdata),
    .st_wstrb_o  (st_wstrb),
    .illegal_o   (illegal),
    .misalign_o  (misalign),
    .ld_funct3_i (f3_q),
    .ld_off_i    (off_q),
    .ld_rdata_i  (mem.mem_rdata),
    .ld_data_o   (ld_data)
  );

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mem_q   <= '0;
      f3_q    <= '0;
      off_q   <= '0;
      rdata_q <= '0;
      err_q   <= ERR_OK;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mem_q   <= mem_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mem_d   = mem_q;
    f3_d    = f3_q;
    off_d   = off_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req.req_valid && req.req_ready) begin
          f3_d  = req.req_funct3;
          off_d = req.req_addr[1:0];
          if (illegal) begin
            state_d = RESP;
            err_d   = ERR_ILLEGAL;
            rdata_d = '0;
          end else if (misalign) begin
            state_d = RESP;
            err_d   = ERR_MISALIGN;
            rdata_d = '0;
          end else begin
            state_d     = ACCESS;
            cnt_d       = '0;
            mem_d.we    = req.req_we;
            mem_d.addr  = {req.req_addr[XLEN-1:2], 2'b00};
            mem_d.wstrb = st_wstrb;
            mem_d.wdata = st_wdata;
          end
        end
      end
      ACCESS: begin
        // mem_ready takes precedence over an expiring timeout
        if (mem.mem_ready) begin
          state_d = RESP;
          err_d   = ERR_OK;
          rdata_d = mem_q.we ? '0 : ld_data;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = RESP;
          err_d   = ERR_BUS;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
        rdata_d = '0;
        err_d   = ERR_OK;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req.req_ready = (state_q == IDLE) && req.en;
  assign req.busy      = (state_q != IDLE);
  assign req.rsp_valid = (state_q == RESP);
  assign req.rsp_rdata = rdata_q;
  assign req.rsp_err   = err_q;

  assign mem.mem_req   = (state_q == ACCESS);
  assign mem.mem_we    = mem_q.we;
  assign mem.mem_addr  = mem_q.addr;
  assign mem.mem_wstrb = mem_q.wstrb;
  assign mem.mem_wdata = mem_q.wdata;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu (TIMEOUT = 4). A transaction-level model
// predicts the handshake and payload outputs every cycle; directed tests add
// hand-computed literal expectations.
module tb_lsu;

  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst;

  lsu_req_if rif ();
  lsu_mem_if mif ();

  lsu #(.DATA_WIDTH(32), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .req (rif),
    .mem (mif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  function automatic int m_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit m_legal(input bit we, input logic [2:0] f3);
    if (we) return f3 < 3'd3;
    return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
  endfunction

  function automatic bit m_misal(input logic [2:0] f3, input logic [1:0] off);
    return (int'(off) % m_size(f3)) != 0;
  endfunction

  function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [1:0] off);
    int s;
    s = m_size(f3);
    return 4'(((1 << s) - 1) << off);
  endfunction

  function automatic logic [31:0] m_wrep(input logic [2:0] f3, input logic [31:0] wd);
    int s;
    s = m_size(f3);
    if (s == 1) return {24'd0, wd[7:0]} * 32'h0101_0101;
    if (s == 2) return {16'd0, wd[15:0]} * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] off,
                                         input logic [31:0] w);
    int s;
    logic [31:0] v, mask;
    s = m_size(f3);
    v = w >> (8 * int'(off));
    if (s < 4) begin
      mask = (32'd1 << (8 * s)) - 32'd1;
      v    = v & mask;
      if (!f3[2] && v[8*s-1]) v = v | ~mask;
    end
    return v;
  endfunction

  bit          m_acc, m_rsp, m_we;
  int          m_n;
  logic [2:0]  m_f3;
  logic [31:0] m_addr, m_wd, m_rdata;
  logic [1:0]  m_err;

  always @(posedge clk) begin
    if (rst) begin
      m_acc   <= 1'b0;
      m_rsp   <= 1'b0;
      m_n     <= 0;
      m_rdata <= '0;
      m_err   <= '0;
    end else if (m_rsp) begin
      m_rsp   <= 1'b0;
      m_rdata <= '0;
      m_err   <= '0;
    end else if (m_acc) begin
      if (mif.mem_ready) begin
        m_acc   <= 1'b0;
        m_rsp   <= 1'b1;
        m_err   <= 2'd0;
        m_rdata <= m_we ? 32'd0 : m_load(m_f3, m_addr[1:0], mif.mem_rdata);
      end else if (m_n + 1 >= TMO) begin
        m_acc   <= 1'b0;
        m_rsp   <= 1'b1;
        m_err   <= 2'd2;
        m_rdata <= '0;
      end else begin
        m_n <= m_n + 1;
      end
    end else if (rif.en && rif.req_valid) begin
      m_we   <= rif.req_we;
      m_f3   <= rif.req_funct3;
      m_addr <= rif.req_addr;
      m_wd   <= rif.req_wdata;
      if (!m_legal(rif.req_we, rif.req_funct3)) begin
        m_rsp <= 1'b1;
        m_err <= 2'd3;
      end else if (m_misal(rif.req_funct3, rif.req_addr[1:0])) begin
        m_rsp <= 1'b1;
        m_err <= 2'd1;
      end else begin
        m_acc <= 1'b1;
        m_n   <= 0;
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("req_ready", 32'(rif.req_ready), 32'(!m_acc && !m_rsp && rif.en));
      chk("busy",      32'(rif.busy),      32'(m_acc || m_rsp));
      chk("mem_req",   32'(mif.mem_req),   32'(m_acc));
      chk("rsp_valid", 32'(rif.rsp_valid), 32'(m_rsp));
      if (m_acc) begin
        chk("mem_addr",  mif.mem_addr,       m_addr & 32'hFFFF_FFFC);
        chk("mem_we",    32'(mif.mem_we),    32'(m_we));
        chk("mem_wstrb", 32'(mif.mem_wstrb), m_we ? 32'(m_strb(m_f3, m_addr[1:0])) : 32'd0);
        if (m_we) chk("mem_wdata", mif.mem_wdata, m_wrep(m_f3, m_wd));
      end
      if (m_rsp) begin
        chk("rsp_rdata", rif.rsp_rdata,    m_rdata);
        chk("rsp_err",   32'(rif.rsp_err), 32'(m_err));
      end else begin
        chk("rsp_rdata_idle", rif.rsp_rdata,    32'd0);
        chk("rsp_err_idle",   32'(rif.rsp_err), 32'd0);
      end
    end
  end

  // ---------------- memory responder ----------------
  int          mem_ready_at = 0;  // 0 = never, k = ready in k-th ACCESS cycle
  logic [31:0] mem_word = '0;
  int          mcyc = 0;

  always @(posedge clk) begin
    #1;
    if (mif.mem_req) begin
      mcyc++;
      mif.mem_ready = (mem_ready_at != 0) && (mcyc == mem_ready_at);
    end else begin
      mcyc = 0;
      mif.mem_ready = 1'b0;
    end
    mif.mem_rdata = mem_word;
  end

  // ---------------- directed stimulus ----------------
  int          o_mem_cyc, o_rsp_k;
  logic        o_we;
  logic [3:0]  o_wstrb;
  logic [31:0] o_addr, o_wdata, o_rdata;
  logic [1:0]  o_err;

  task automatic run_req(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input int rdy_at, input logic [31:0] word,
                         input bit drop_en);
    mem_ready_at = rdy_at;
    mem_word     = word;
    o_mem_cyc    = 0;
    o_rsp_k      = -1;
    @(posedge clk); #1;
    rif.req_valid  = 1'b1;
    rif.req_we     = we;
    rif.req_funct3 = f3;
    rif.req_addr   = addr;
    rif.req_wdata  = wd;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      rif.req_valid = 1'b0;
      if (drop_en) rif.en = 1'b0;
      @(negedge clk);
      if (mif.mem_req) begin
        if (o_mem_cyc == 0) begin
          o_we    = mif.mem_we;
          o_addr  = mif.mem_addr;
          o_wstrb = mif.mem_wstrb;
          o_wdata = mif.mem_wdata;
        end
        o_mem_cyc++;
      end
      if (rif.rsp_valid) begin
        o_rsp_k = k;
        o_rdata = rif.rsp_rdata;
        o_err   = rif.rsp_err;
        break;
      end
    end
    chk("rsp_seen", 32'(o_rsp_k > 0), 32'd1);
    rif.en = 1'b1;
  endtask

  initial begin
    rst            = 1'b1;
    rif.en         = 1'b0;
    rif.req_valid  = 1'b0;
    rif.req_we     = 1'b0;
    rif.req_funct3 = '0;
    rif.req_addr   = '0;
    rif.req_wdata  = '0;
    mif.mem_ready  = 1'b0;
    mif.mem_rdata  = '0;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", 32'(rif.req_ready), 32'd0);
    chk("rst_busy",      32'(rif.busy),      32'd0);
    chk("rst_mem_req",   32'(mif.mem_req),   32'd0);
    chk("rst_rsp_valid", 32'(rif.rsp_valid), 32'd0);
    chk("rst_mem_addr",  mif.mem_addr,       32'd0);
    chk("rst_mem_wstrb", 32'(mif.mem_wstrb), 32'd0);
    cmp_on = 1'b1;
    @(posedge clk); #1 rif.en = 1'b1;
    @(negedge clk);
    chk("en_req_ready", 32'(rif.req_ready), 32'd1);

    // LB / LBU at 0x103
    run_req(1'b0, 3'b000, 32'h0000_0103, 32'd0, 1, 32'h80FF_1234, 1'b0);
    chk("lb_addr",  o_addr,          32'h0000_0100);
    chk("lb_wstrb", 32'(o_wstrb),    32'd0);
    chk("lb_lat",   32'(o_rsp_k),    32'd2);
    chk("lb_rdata", o_rdata,         32'hFFFF_FF80);
    chk("lb_err",   32'(o_err),      32'd0);
    run_req(1'b0, 3'b100, 32'h0000_0103, 32'd0, 1, 32'h80FF_1234, 1'b0);
    chk("lbu_rdata", o_rdata, 32'h0000_0080);

    // SH at 0x102, memory ready in the 4th ACCESS cycle
    run_req(1'b1, 3'b001, 32'h0000_0102, 32'h1234_ABCD, 4, 32'hFFFF_FFFF, 1'b0);
    chk("sh_we",    32'(o_we),      32'd1);
    chk("sh_wstrb", 32'(o_wstrb),   32'hC);
    chk("sh_wdata", o_wdata,        32'hABCD_ABCD);
    chk("sh_cyc",   32'(o_mem_cyc), 32'd4);
    chk("sh_rdata", o_rdata,        32'd0);

    // Byte store and half loads
    run_req(1'b1, 3'b000, 32'h0000_0201, 32'h0000_00EF, 1, 32'd0, 1'b0);
    chk("sb_wstrb", 32'(o_wstrb), 32'h2);
    chk("sb_wdata", o_wdata,      32'hEFEF_EFEF);
    run_req(1'b0, 3'b001, 32'h0000_0106, 32'd0, 2, 32'h8001_0000, 1'b0);
    chk("lh_rdata", o_rdata, 32'hFFFF_8001);
    run_req(1'b0, 3'b101, 32'h0000_0106, 32'd0, 1, 32'h8001_0000, 1'b0);
    chk("lhu_rdata", o_rdata, 32'h0000_8001);

    // Error paths without memory access
    run_req(1'b0, 3'b010, 32'h0000_0101, 32'd0, 1, 32'd0, 1'b0);
    chk("lw_mis_err", 32'(o_err),     32'd1);
    chk("lw_mis_lat", 32'(o_rsp_k),   32'd1);
    chk("lw_mis_cyc", 32'(o_mem_cyc), 32'd0);
    run_req(1'b0, 3'b111, 32'h0000_0100, 32'd0, 1, 32'd0, 1'b0);
    chk("ld_ill_err", 32'(o_err),     32'd3);
    chk("ld_ill_cyc", 32'(o_mem_cyc), 32'd0);
    run_req(1'b1, 3'b011, 32'h0000_0100, 32'd0, 1, 32'd0, 1'b0);
    chk("st_ill_err", 32'(o_err), 32'd3);
    run_req(1'b1, 3'b001, 32'h0000_0103, 32'd0, 1, 32'd0, 1'b0);
    chk("sh_mis_err", 32'(o_err), 32'd1);

    // Bus timeout, and mem_ready on the final allowed cycle
    run_req(1'b0, 3'b010, 32'h0000_0020, 32'd0, 0, 32'h1111_1111, 1'b0);
    chk("tmo_cyc",   32'(o_mem_cyc), 32'd4);
    chk("tmo_err",   32'(o_err),     32'd2);
    chk("tmo_rdata", o_rdata,        32'd0);
    run_req(1'b0, 3'b010, 32'h0000_0024, 32'd0, 4, 32'h1357_9BDF, 1'b0);
    chk("rdy4_err",   32'(o_err), 32'd0);
    chk("rdy4_rdata", o_rdata,    32'h1357_9BDF);

    // Reset during the 2nd ACCESS cycle
    mem_ready_at = 0;
    @(posedge clk); #1;
    rif.req_valid  = 1'b1;
    rif.req_we     = 1'b0;
    rif.req_funct3 = 3'b010;
    rif.req_addr   = 32'h0000_0030;
    @(posedge clk); #1 rif.req_valid = 1'b0;
    @(negedge clk);
    chk("rstx_acc", 32'(mif.mem_req), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rstx_mem_req",  32'(mif.mem_req),   32'd0);
    chk("rstx_busy",     32'(rif.busy),      32'd0);
    chk("rstx_rsp",      32'(rif.rsp_valid), 32'd0);
    chk("rstx_mem_addr", mif.mem_addr,       32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("rstx_no_rsp", 32'(rif.rsp_valid), 32'd0);
    end
    run_req(1'b0, 3'b010, 32'h0000_0010, 32'd0, 1, 32'hDEAD_BEEF, 1'b0);
    chk("post_rst_rdata", o_rdata, 32'hDEAD_BEEF);

    // en = 0 blocks acceptance
    @(posedge clk); #1;
    rif.en         = 1'b0;
    rif.req_valid  = 1'b1;
    rif.req_we     = 1'b0;
    rif.req_funct3 = 3'b010;
    rif.req_addr   = 32'h0000_0050;
    repeat (3) begin
      @(negedge clk);
      chk("en0_ready", 32'(rif.req_ready), 32'd0);
      chk("en0_busy",  32'(rif.busy),      32'd0);
    end
    @(posedge clk); #1;
    rif.req_valid = 1'b0;
    rif.en        = 1'b1;

    // en dropped during ACCESS: transaction still completes
    run_req(1'b0, 3'b010, 32'h0000_0040, 32'd0, 3, 32'hCAFE_F00D, 1'b1);
    chk("en_drop_rdata", o_rdata,     32'hCAFE_F00D);
    chk("en_drop_cyc",   32'(o_mem_cyc), 32'd3);

    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
Load/store unit directly downstream of the ALU in the rv32 core. It consumes the ALU's effective address for load/store instructions and runs a handshaked access on the data-memory port. It performs byte/half/word lane alignment, store-strobe generation, load sign/zero extension, misalignment detection and a bus timeout. It returns a single-cycle response to the control path, which stalls while `busy` is high.

Parameters:
DATA_WIDTH, 32, datapath width. Only 32 is supported, because the strobe width is fixed at 4.
TIMEOUT, 255, maximum cycles in ACCESS waiting for mem_ready before a bus error is raised. Must be ≥1.

Ports:
clk  in  1  clock; all logic is on the rising edge
rst  in  1  reset, synchronous, active-high
en  in  1  global enable; when 0, no new request is accepted
req_valid  in  1  load/store request present
req_ready  out  1  lsu can accept a request
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RV32 funct3: LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010
req_addr  in  32  effective address (ALU result)
req_wdata  in  32  store data (rs2)
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  32  extended load data; 0 for stores and errors
rsp_err  out  2  00 ok, 01 misaligned, 10 bus timeout, 11 illegal funct3
busy  out  1  high whenever state ≠ IDLE
mem_req  out  1  memory request, held until mem_ready
mem_we  out  1  memory write
mem_addr  out  32  word address: {req_addr[31:2], 2'b00}
mem_wstrb  out  4  byte-lane strobes (0 for loads)
mem_wdata  out  32  lane-replicated store data
mem_ready  in  1  memory accepts/completes the access this cycle
mem_rdata  in  32  read word, valid when mem_ready && !mem_we

Behaviour:
- FSM states:
  - IDLE: req_ready = en.
  - ACCESS: mem_req = 1.
  - RESP: rsp_valid = 1.
- Reset (rst = 1 at an edge):
  - state goes to IDLE and the timeout counter goes to 0.
  - All outputs become 0, except req_ready, which follows en.
  - This applies mid-transaction: mem_req drops at that edge and no response is produced.
- Acceptance: when req_valid && req_ready, the request is registered (we, funct3, addr[1:0], address, data).
- Accepted request with illegal funct3 (loads: 011, 110, 111; stores: any code ≥ 011):
  - Next state is RESP with rsp_err = 11.
  - No memory access is made.
- Accepted request that is misaligned (half with addr[0] = 1; word with addr[1:0] ≠ 0):
  - Next state is RESP with rsp_err = 01.
  - No memory access is made.
- Otherwise the next state is ACCESS. mem_* are registered and valid on the first ACCESS cycle.
- Store lane and strobe rules:
  - SB: wdata = {4{req_wdata[7:0]}}, wstrb = 0001 << addr[1:0].
  - SH: wdata = {2{req_wdata[15:0]}}, wstrb = addr[1] ? 1100 : 0011.
  - SW: wdata = req_wdata, wstrb = 1111.
- Leaving ACCESS:
  - mem_ready = 1 in ACCESS: capture the extended load data and go to RESP with rsp_err = 00.
  - The counter increments each ACCESS cycle without mem_ready. When counter == TIMEOUT-1 and mem_ready is still 0, go to RESP with rsp_err = 10 and rsp_rdata = 0.
  - mem_ready and timeout in the same cycle: mem_ready wins.
- Load extraction:
  - Byte = mem_rdata[8*off +: 8]; half = mem_rdata[16*addr[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- RESP: lasts exactly 1 cycle, then IDLE. The counter clears on entering ACCESS.
- Latency:
  - Accept at edge N; mem_req is high in cycle N+1.
  - If mem_ready arrives in cycle N+1, rsp_valid is high in cycle N+2.
  - An error path without memory access gives rsp_valid in cycle N+1.
- Throughput: req_ready is low outside IDLE, so the next request can be accepted the cycle after RESP (minimum 3 cycles per access).
- Enable: en = 0 blocks acceptance only. An in-flight transaction completes normally.
- Hold rules:
  - mem_addr, mem_we, mem_wstrb and mem_wdata are stable while mem_req is high.
  - rsp_rdata and rsp_err are meaningful only when rsp_valid is high. They are cleared to 0 on IDLE entry.

Decomposition:
- Shared package:
  - funct3 load/store encodings.
  - rsp_err codes (ERR_OK, ERR_MISALIGN, ERR_BUS, ERR_ILLEGAL).
  - FSM state encodings (IDLE, ACCESS, RESP).
- One natural sub-module, lsu_align: purely combinational.
  - Store-lane replication and strobe generation.
  - Load byte/half selection with sign/zero extension.
  - Misaligned and illegal-funct3 detection.
- The top module owns the FSM, the timeout counter and the registers.

Test Plan:
- LB at 0x0000_0103, mem_rdata = 0x80FF_1234, mem_ready in the first ACCESS cycle:
  - mem_addr = 0x0000_0100 and mem_wstrb = 0000.
  - rsp_rdata = 0xFFFF_FF80, rsp_err = 00, two cycles after acceptance.
  - Repeat as LBU: rsp_rdata = 0x0000_0080.
- SH at 0x0000_0102 with wdata 0x1234_ABCD, mem_ready delayed 3 cycles:
  - mem_we = 1, mem_wstrb = 1100, mem_wdata = 0xABCD_ABCD, all held for 4 cycles.
  - Then rsp_valid with rsp_rdata = 0.
- LW at 0x0000_0101 → no mem_req ever; rsp_valid the next cycle with rsp_err = 01. funct3 = 111 load → rsp_err = 11.
- TIMEOUT = 4, mem_ready held 0:
  - mem_req high for exactly 4 cycles, then rsp_err = 10 with rsp_rdata = 0.
  - Variant with mem_ready on the 4th cycle → rsp_err = 00.
- rst asserted in the 2nd ACCESS cycle:
  - Next cycle: mem_req = 0, busy = 0, state IDLE, and no rsp_valid.
  - A subsequent LW at 0x10 with mem_rdata 0xDEAD_BEEF returns 0xDEAD_BEEF.
- en = 0 with req_valid = 1 → req_ready = 0 and no acceptance. en dropped during ACCESS → the transaction still completes with rsp_valid.
